// File: rtl/mod_display_contador.sv
// Counter value to 2-digit multiplexed 7-segment display.
// Sequential double-dabble BCD conversion plus digit refresh mux.
module mod_display_contador #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] Q,
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic [7:0] BCD,
    output logic       BUSY
);

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be 2 or more");
    end

    localparam int RW = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] ZERO  = 7'b1000000;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [12:0] sh;
    logic [12:0] sh_nx;
    logic [12:0] adj;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nx;
    logic [4:0]  last_value;
    logic [4:0]  last_nx;
    logic [7:0]  bcd_nx;
    logic [RW-1:0] rcnt;
    logic        sel;
    logic [6:0]  raw;
    logic [6:0]  seg_nx;

    // Active-low pattern for one BCD digit; impossible codes blank.
    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = BLANK;
        endcase
    endfunction

    assign BUSY = (state != IDLE);

    // Add-3 correction on both BCD nibbles before each shift.
    always_comb begin
        adj = sh;
        if (sh[8:5] >= 4'd5)
            adj[8:5] = sh[8:5] + 4'd3;
        if (sh[12:9] >= 4'd5)
            adj[12:9] = sh[12:9] + 4'd3;
    end

    // Conversion FSM next-state and datapath.
    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        cnt_nx   = cnt;
        last_nx  = last_value;
        bcd_nx   = BCD;
        unique case (state)
            IDLE: begin
                if (Q != last_value) begin
                    sh_nx    = {8'b0, Q};
                    last_nx  = Q;
                    cnt_nx   = 3'd0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                sh_nx  = {adj[11:0], 1'b0};
                cnt_nx = cnt + 3'd1;
                if (cnt == 3'd4)
                    state_nx = DONE;
            end
            DONE: begin
                bcd_nx   = sh[12:5];
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Conversion state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            sh         <= '0;
            cnt        <= '0;
            last_value <= '0;
            BCD        <= 8'h00;
        end else begin
            state      <= state_nx;
            sh         <= sh_nx;
            cnt        <= cnt_nx;
            last_value <= last_nx;
            BCD        <= bcd_nx;
        end
    end

    // Segment pattern for the digit currently selected; tens zero blanks.
    always_comb begin
        raw = dec(BCD[3:0]);
        if (sel)
            raw = (BCD[7:4] == 4'd0) ? BLANK : dec(BCD[7:4]);
        seg_nx = SEG_ACTIVE_LOW ? raw : ~raw;
    end

    // Refresh divider, digit select and registered display outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rcnt <= '0;
            sel  <= 1'b0;
            AN   <= 2'b10;
            SEG  <= SEG_ACTIVE_LOW ? ZERO : ~ZERO;
        end else begin
            if (rcnt == R_LAST) begin
                rcnt <= '0;
                sel  <= ~sel;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
            AN  <= sel ? 2'b01 : 2'b10;
            SEG <= seg_nx;
        end
    end

endmodule

// File: tb/tb_mod_display_contador.sv
// Bench for mod_display_contador: directed scenarios plus random Q/reset
// traffic against a cycle-level behavioural model.
module tb_mod_display_contador;

    localparam int DIV = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] Q   = 5'd0;
    logic [6:0] SEG;
    logic [1:0] AN;
    logic [7:0] BCD;
    logic       BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                              7'b0110000, 7'b0011001, 7'b0010010,
                              7'b0000010, 7'b1111000, 7'b0000000,
                              7'b0010000};

    // behavioural model state
    int         m_last;
    int         m_left;
    int         m_target;
    logic [7:0] m_bcd;
    int         m_rc;
    bit         m_tens;
    logic [6:0] m_seg;
    logic [1:0] m_an;

    always #5 CLK = ~CLK;

    mod_display_contador #(
        .REFRESH_DIV(DIV),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .Q   (Q),
        .SEG (SEG),
        .AN  (AN),
        .BCD (BCD),
        .BUSY(BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [6:0] shown(input logic [7:0] b, input bit tens);
        if (!tens)
            return pat[b[3:0]];
        if (b[7:4] == 4'd0)
            return 7'b1111111;
        return pat[b[7:4]];
    endfunction

    task automatic model_edge();
        if (RST) begin
            m_last = 0;
            m_left = 0;
            m_bcd  = 8'h00;
            m_rc   = 0;
            m_tens = 1'b0;
            m_seg  = 7'b1000000;
            m_an   = 2'b10;
        end else begin
            m_seg = shown(m_bcd, m_tens);
            m_an  = m_tens ? 2'b01 : 2'b10;
            if (m_rc == DIV - 1) begin
                m_rc   = 0;
                m_tens = !m_tens;
            end else begin
                m_rc++;
            end
            if (m_left == 0) begin
                if (int'(Q) != m_last) begin
                    m_last   = int'(Q);
                    m_target = int'(Q);
                    m_left   = 6;
                end
            end else begin
                m_left--;
                if (m_left == 0)
                    m_bcd = to_bcd(m_target);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        chk("bcd", 32'(BCD), 32'(m_bcd));
        chk("busy", 32'(BUSY), 32'(m_left != 0));
        chk("an", 32'(AN), 32'(m_an));
        chk("seg", 32'(SEG), 32'(m_seg));
    endtask

    initial begin
        int n;
        RST = 1'b1;
        Q   = 5'd0;
        repeat (10) tick();
        chk("rst_bcd", 32'(BCD), 32'h00);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_an", 32'(AN), 32'(2'b10));
        chk("rst_seg", 32'(SEG), 32'(7'b1000000));

        RST = 1'b0;
        Q   = 5'd31;
        tick();
        chk("busy_start", 32'(BUSY), 32'd1);
        n = 0;
        while (BUSY && n < 20) begin
            tick();
            n++;
        end
        chk("busy_len", 32'(n), 32'd6);
        chk("bcd31", 32'(BCD), 32'h31);

        for (int v = 0; v < 32; v++) begin
            Q = 5'(v);
            repeat (8) tick();
            chk("sweep", 32'(BCD), 32'(to_bcd(v)));
        end

        Q = 5'd7;
        repeat (3) tick();
        Q = 5'd12;
        repeat (4) tick();
        chk("first_done", 32'(BCD), 32'h07);
        chk("first_idle", 32'(BUSY), 32'd0);
        tick();
        chk("second_start", 32'(BUSY), 32'd1);
        repeat (6) tick();
        chk("second_done", 32'(BCD), 32'h12);

        Q = 5'd5;
        repeat (8) tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            if (m_an == 2'b10)
                chk("units5", 32'(SEG), 32'(7'b0010010));
            else
                chk("tens5", 32'(SEG), 32'(7'b1111111));
        end
        Q = 5'd13;
        repeat (8) tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            if (m_an == 2'b10)
                chk("units13", 32'(SEG), 32'(7'b0110000));
            else
                chk("tens13", 32'(SEG), 32'(7'b1111001));
        end

        Q = 5'd25;
        repeat (3) tick();
        RST = 1'b1;
        tick();
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_bcd", 32'(BCD), 32'h00);
        chk("abort_an", 32'(AN), 32'(2'b10));
        RST = 1'b0;
        repeat (8) tick();
        chk("restart25", 32'(BCD), 32'h25);

        for (int it = 0; it < 300; it++) begin
            Q   = 5'($urandom_range(0, 31));
            RST = ($urandom_range(0, 19) == 0);
            tick();
            RST = 1'b0;
            repeat ($urandom_range(0, 10)) tick();
        end
        repeat (10) tick();
        chk("final", 32'(BCD), 32'(to_bcd(int'(Q))));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
